card_shuffler: RTL and testbench

CARD_SHUFFLER -- requirements
Module: card_shuffler

---
 rtl/card_shuffler.sv | 186 ++++++++++++++++++
 tb/tb_card_shuffler.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/card_shuffler.sv
// Card colour shuffler: builds a pair-wise colour permutation with a free-running LFSR
// (Fisher-Yates with rejection sampling) and streams it into card memory.
module card_shuffler #(
    parameter int          CARD_MAX  = 24,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        compute_colors_en,
    input  logic [4:0]  num_of_cards,
    output logic        compute_done,
    output logic        write_card_en,
    output logic [4:0]  write_card_address,
    output logic [11:0] write_card_color,
    output logic [1:0]  write_card_state
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SHUFFLE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [4:0]  n_q, n_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [3:0]  perm_q [CARD_MAX];
    logic [3:0]  perm_d [CARD_MAX];

    logic        done_q, done_d;
    logic        wen_q, wen_d;
    logic [4:0]  addr_q, addr_d;
    logic [11:0] color_q, color_d;
    logic [1:0]  cstate_q, cstate_d;

    logic [4:0]  n_req, n_eff, rnd;

    function automatic logic [11:0] palette(input logic [3:0] k);
        case (k)
            4'd0:    palette = 12'hF00;
            4'd1:    palette = 12'h0F0;
            4'd2:    palette = 12'h00F;
            4'd3:    palette = 12'hFF0;
            4'd4:    palette = 12'hF0F;
            4'd5:    palette = 12'h0FF;
            4'd6:    palette = 12'hF80;
            4'd7:    palette = 12'h8F0;
            4'd8:    palette = 12'h08F;
            4'd9:    palette = 12'hF08;
            4'd10:   palette = 12'h888;
            4'd11:   palette = 12'hFFF;
            default: palette = 12'h000;
        endcase
    endfunction

    // Even card count clamped to 4..CARD_MAX
    always_comb begin
        n_req = num_of_cards & 5'b11110;
        if (n_req < 5'd4)
            n_eff = 5'd4;
        else if (int'(n_req) > CARD_MAX)
            n_eff = 5'(CARD_MAX);
        else
            n_eff = n_req;
    end

    assign rnd    = lfsr_q[4:0];
    assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        n_d      = n_q;
        perm_d   = perm_q;
        done_d   = 1'b0;
        wen_d    = 1'b0;
        addr_d   = '0;
        color_d  = '0;
        cstate_d = '0;

        case (state_q)
            S_IDLE: begin
                if (compute_colors_en) begin
                    state_d = S_INIT;
                    idx_d   = '0;
                    n_d     = n_eff;
                end
            end
            S_INIT: begin
                if (!compute_colors_en) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else begin
                    perm_d[idx_q] = idx_q[4:1];
                    if (idx_q == n_q - 5'd1) begin
                        state_d = S_SHUFFLE;
                        idx_d   = n_q - 5'd1;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            S_SHUFFLE: begin
                if (!compute_colors_en) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else if (rnd <= idx_q) begin
                    // Draws above idx are rejected and retried next cycle
                    perm_d[idx_q] = perm_q[rnd];
                    perm_d[rnd]   = perm_q[idx_q];
                    if (idx_q == 5'd1) begin
                        state_d = S_WRITE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q - 5'd1;
                    end
                end
            end
            S_WRITE: begin
                if (!compute_colors_en) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else begin
                    wen_d    = 1'b1;
                    addr_d   = idx_q;
                    color_d  = palette(perm_q[idx_q]);
                    cstate_d = 2'b01;
                    if (idx_q == n_q - 5'd1) begin
                        state_d = S_DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            S_DONE: begin
                if (compute_colors_en) begin
                    done_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            n_q      <= '0;
            lfsr_q   <= LFSR_SEED;
            for (int unsigned k = 0; k < CARD_MAX; k++) perm_q[k] <= '0;
            done_q   <= 1'b0;
            wen_q    <= 1'b0;
            addr_q   <= '0;
            color_q  <= '0;
            cstate_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            n_q      <= n_d;
            lfsr_q   <= lfsr_d;
            perm_q   <= perm_d;
            done_q   <= done_d;
            wen_q    <= wen_d;
            addr_q   <= addr_d;
            color_q  <= color_d;
            cstate_q <= cstate_d;
        end
    end

    assign compute_done       = done_q;
    assign write_card_en      = wen_q;
    assign write_card_address = addr_q;
    assign write_card_color   = color_q;
    assign write_card_state   = cstate_q;

endmodule

// File: tb/tb_card_shuffler.sv
// Scoreboard bench for card_shuffler: an arithmetic LFSR + Fisher-Yates model predicts every
// card write; a negedge monitor pops and compares each strobe.
module tb_card_shuffler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [4:0]  nc = '0;
    logic        compute_done;
    logic        write_card_en;
    logic [4:0]  write_card_address;
    logic [11:0] write_card_color;
    logic [1:0]  write_card_state;

    card_shuffler #(.CARD_MAX(24), .LFSR_SEED(16'hACE1)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .compute_colors_en  (en),
        .num_of_cards       (nc),
        .compute_done       (compute_done),
        .write_card_en      (write_card_en),
        .write_card_address (write_card_address),
        .write_card_color   (write_card_color),
        .write_card_state   (write_card_state)
    );

    always #5 clk = ~clk;

    localparam logic [11:0] PAL [12] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'hF0F, 12'h0FF,
                                         12'hF80, 12'h8F0, 12'h08F, 12'hF08, 12'h888, 12'hFFF};

    typedef struct {
        logic [4:0]  addr;
        logic [11:0] color;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int unsigned m_lfsr = 32'hACE1;
    int          exp_n;
    int          exp_ticks;
    int          wr_count;
    logic [11:0] obs_color [32];
    logic [11:0] map_a [32];

    function automatic void check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic int unsigned lfsr_step(input int unsigned v);
        int unsigned b;
        b = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
        return ((v >> 1) | (b << 15)) & 32'hFFFF;
    endfunction

    // One clock edge; the reference LFSR follows the same reset/advance rule
    task automatic tick();
        @(posedge clk);
        if (!rst_n) m_lfsr = 32'hACE1;
        else        m_lfsr = lfsr_step(m_lfsr);
        #1;
    endtask

    // Predict the full run assuming the DUT is idle and en is raised before the next edge
    task automatic predict(input logic [4:0] num);
        int          n, i, r, rej, tmp, guard;
        int          perm [24];
        int unsigned cur;
        exp_t        e;
        n = int'(num) & 30;
        if (n < 4)  n = 4;
        if (n > 24) n = 24;
        for (int k = 0; k < n; k++) perm[k] = k / 2;
        cur = m_lfsr;
        repeat (n + 1) cur = lfsr_step(cur);
        i = n - 1;
        rej = 0;
        guard = 0;
        while (i >= 1 && guard < 100000) begin
            r = int'(cur & 31);
            if (r <= i) begin
                tmp = perm[i]; perm[i] = perm[r]; perm[r] = tmp;
                i--;
            end else begin
                rej++;
            end
            cur = lfsr_step(cur);
            guard++;
        end
        for (int a = 0; a < n; a++) begin
            e.addr  = 5'(a);
            e.color = PAL[perm[a]];
            sb.push_back(e);
        end
        exp_n     = n;
        exp_ticks = 2 * n + (n - 1 + rej) + 2;
    endtask

    task automatic start_run(input logic [4:0] num);
        nc = num;
        wr_count = 0;
        for (int a = 0; a < 32; a++) obs_color[a] = 12'h000;
        predict(num);
        en = 1'b1;
    endtask

    task automatic run_to_done();
        int t;
        bit seen;
        int cnt;
        t = 0;
        seen = 1'b0;
        while (!seen && t < exp_ticks + 50) begin
            tick();
            t++;
            seen = compute_done;
        end
        check_eq("done_seen", 32'(seen), 32'd1);
        if (seen) check_eq("done_latency", 32'(t), 32'(exp_ticks));
        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        check_eq("write_count", 32'(wr_count), 32'(exp_n));
        for (int k = 0; k < 12; k++) begin
            cnt = 0;
            for (int a = 0; a < exp_n; a++) if (obs_color[a] == PAL[k]) cnt++;
            check_eq($sformatf("pair_count_%0d", k), 32'(cnt), (k < exp_n / 2) ? 32'd2 : 32'd0);
        end
        en = 1'b0;
        tick();
        check_eq("done_fall", 32'(compute_done), 32'd0);
    endtask

    task automatic full_run(input logic [4:0] num, input int gap);
        repeat (gap) tick();
        start_run(num);
        run_to_done();
    endtask

    task automatic do_reset();
        en = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (write_card_en) begin
            wr_count++;
            obs_color[write_card_address] = write_card_color;
            if (sb.size() == 0) begin
                check_eq("unexpected_write", 32'(write_card_address), 32'hFFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("write_addr", 32'(write_card_address), 32'(e.addr));
                check_eq("write_color", 32'(write_card_color), 32'(e.color));
                check_eq("write_state", 32'(write_card_state), 32'd1);
            end
        end
        if (compute_done) check_eq("done_wen_exclusive", 32'(write_card_en), 32'd0);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        bit differ;
        int t;

        repeat (3) tick();
        check_eq("rst_done", 32'(compute_done), 32'd0);
        check_eq("rst_wen", 32'(write_card_en), 32'd0);
        check_eq("rst_addr", 32'(write_card_address), 32'd0);
        check_eq("rst_color", 32'(write_card_color), 32'd0);
        check_eq("rst_state", 32'(write_card_state), 32'd0);
        check_eq("rst_lfsr", 32'(dut.lfsr_q), 32'hACE1);
        rst_n = 1'b1;

        // Same N, start offset by 5 cycles from reset: mapping must change
        full_run(5'd24, 0);
        for (int a = 0; a < 32; a++) map_a[a] = obs_color[a];
        do_reset();
        full_run(5'd24, 5);
        differ = 1'b0;
        for (int a = 0; a < 24; a++) if (map_a[a] != obs_color[a]) differ = 1'b1;
        check_eq("seed_timing_differs", 32'(differ), 32'd1);

        full_run(5'd16, 3);
        full_run(5'd31, 1);
        full_run(5'd1, 2);
        full_run(5'd0, 0);
        full_run(5'd25, 4);

        // Abort during the third write cycle
        start_run(5'd16);
        while (sb.size() > 2) void'(sb.pop_back());
        seen = 1'b0;
        t = 0;
        while (!seen && t < 300) begin
            tick();
            t++;
            seen = write_card_en && (write_card_address == 5'd1);
        end
        check_eq("abort_reach_w2", 32'(seen), 32'd1);
        en = 1'b0;
        tick();
        check_eq("abort_wen", 32'(write_card_en), 32'd0);
        repeat (4) begin
            tick();
            check_eq("abort_done_low", 32'(compute_done), 32'd0);
        end
        check_eq("abort_sb_drained", 32'(sb.size()), 32'd0);
        full_run(5'd16, 0);

        // Reset while shuffling, en held high through release
        nc = 5'd16;
        en = 1'b1;
        repeat (16 + 3) tick();
        rst_n = 1'b0;
        tick();
        check_eq("midrst_done", 32'(compute_done), 32'd0);
        check_eq("midrst_wen", 32'(write_card_en), 32'd0);
        check_eq("midrst_addr", 32'(write_card_address), 32'd0);
        check_eq("midrst_color", 32'(write_card_color), 32'd0);
        check_eq("midrst_state", 32'(write_card_state), 32'd0);
        check_eq("midrst_lfsr", 32'(dut.lfsr_q), 32'hACE1);
        rst_n = 1'b1;
        start_run(5'd16);
        run_to_done();

        for (int k = 0; k < 6; k++) full_run(5'($urandom_range(0, 31)), int'($urandom_range(0, 20)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
